// File: rtl/axi_lite_pattern_master.sv
// AXI4-Lite pattern generator/checker: writes SEED+i over an address window, reads it back, counts failed beats.
// Optional watchdog (TIMEOUT port) enabled with `define AXI_LITE_TIMEOUT_EN.
module axi_lite_pattern_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TXN_COUNT = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = {C_M_AXI_ADDR_WIDTH{1'b0}},
    parameter int C_ADDR_STRIDE = 4,
    parameter int C_TIMEOUT_CYCLES = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              INIT_AXI_TXN,
    input  logic [1:0]                        MODE,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     SEED,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [7:0]                        ERR_COUNT,
    output logic                              BUSY,
`ifdef AXI_LITE_TIMEOUT_EN
    output logic                              TIMEOUT,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [7:0]    LAST_IDX = 8'(C_TXN_COUNT - 1);
    localparam logic [AW-1:0] STRIDE   = AW'(C_ADDR_STRIDE);
    localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [1:0] MODE_INTERLEAVE = 2'b00;
    localparam logic [1:0] MODE_RD_ONLY    = 2'b10;
    localparam logic [1:0] MODE_WR_THEN_RD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            init_q;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   seed_q, seed_d;
    logic [7:0]      idx_q, idx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic            bready_q, bready_d, rready_q, rready_d;
    logic            done_q, done_d, busy_q, busy_d, error_q, error_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            start_s, start_acc_s, last_s, err_inc_s;
`ifdef AXI_LITE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT_CYCLES - 1);
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d, active_s, tmo_hit_s;
`endif

    // Next-state, handshake tracking, pattern advance and error accounting
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        err_inc_s = 1'b0;
        start_s   = INIT_AXI_TXN && !init_q;
        start_acc_s = start_s && ((state_q == S_IDLE) || (state_q == S_DONE));
        last_s    = (idx_q == LAST_IDX);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc_s) begin
                    mode_d = MODE;
                    seed_d = SEED;
                    idx_d  = 8'd0;
                    addr_d = C_BASE_ADDR;
                    data_d = SEED;
                    if (MODE == MODE_RD_ONLY) begin
                        state_d   = S_RD_REQ;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_WR_REQ: begin
                // each channel retires on its own handshake; move on once both have
                awvalid_d = awvalid_q && !M_AXI_AWREADY;
                wvalid_d  = wvalid_q && !M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d  = 1'b0;
                    err_inc_s = (M_AXI_BRESP != 2'b00);
                    if (mode_q == MODE_INTERLEAVE) begin
                        state_d   = S_RD_REQ;
                        arvalid_d = 1'b1;
                    end else if (!last_s) begin
                        idx_d     = idx_q + 8'd1;
                        addr_d    = addr_q + STRIDE;
                        data_d    = data_q + ONE;
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else if (mode_q == MODE_WR_THEN_RD) begin
                        idx_d     = 8'd0;
                        addr_d    = C_BASE_ADDR;
                        data_d    = seed_q;
                        state_d   = S_RD_REQ;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_WR_RESP;
                end
            end
            S_RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_RESP;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    rready_d  = 1'b0;
                    err_inc_s = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_q);
                    if (last_s) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        addr_d = addr_q + STRIDE;
                        data_d = data_q + ONE;
                        if (mode_q == MODE_INTERLEAVE) begin
                            state_d   = S_WR_REQ;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end else begin
                            state_d   = S_RD_REQ;
                            arvalid_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = S_RD_RESP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
                bready_d  = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
`ifdef AXI_LITE_TIMEOUT_EN
        active_s  = (state_q != S_IDLE) && (state_q != S_DONE);
        tmo_hit_s = active_s && (tmo_cnt_q >= TMO_LAST);
        if (tmo_hit_s) begin
            state_d   = S_DONE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
            bready_d  = 1'b0;
            rready_d  = 1'b0;
            err_inc_s = 1'b1;
            timeout_d = 1'b1;
        end else if (start_acc_s) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
        tmo_cnt_d = (active_s && (state_d == state_q)) ? (tmo_cnt_q + 16'd1) : 16'd0;
`endif
        if (start_acc_s) begin
            err_cnt_d = 8'd0;
        end else if (err_inc_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
        error_d = (err_cnt_d != 8'd0);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            init_q    <= 1'b0;
            mode_q    <= 2'b00;
            seed_q    <= {DW{1'b0}};
            idx_q     <= 8'd0;
            addr_q    <= {AW{1'b0}};
            data_q    <= {DW{1'b0}};
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= 8'd0;
`ifdef AXI_LITE_TIMEOUT_EN
            tmo_cnt_q <= 16'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            init_q    <= INIT_AXI_TXN;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
`ifdef AXI_LITE_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign TXN_DONE      = done_q;
    assign BUSY          = busy_q;
    assign ERROR         = error_q;
    assign ERR_COUNT     = err_cnt_q;
`ifdef AXI_LITE_TIMEOUT_EN
    assign TIMEOUT       = timeout_q;
`endif
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = {(DW/8){1'b1}};
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axi_lite_pattern_master.sv
// Directed bench: table of runs against a configurable AXI-Lite memory slave, plus reset/start corner sequences.
module tb_axi_lite_pattern_master;
    logic ACLK = 1'b0;
    logic ARESET, INIT_AXI_TXN;
    logic [1:0] MODE;
    logic [31:0] SEED;
    logic TXN_DONE, ERROR, BUSY;
    logic [7:0] ERR_COUNT;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0] M_AXI_WSTRB;
    logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
    logic M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
`ifdef AXI_LITE_TIMEOUT_EN
    logic TIMEOUT;
`endif

    always #5 ACLK = ~ACLK;

    axi_lite_pattern_master #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_TXN_COUNT(4),
        .C_BASE_ADDR(32'h0000_0000), .C_ADDR_STRIDE(4), .C_TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .INIT_AXI_TXN(INIT_AXI_TXN), .MODE(MODE), .SEED(SEED),
        .TXN_DONE(TXN_DONE), .ERROR(ERROR), .ERR_COUNT(ERR_COUNT), .BUSY(BUSY),
`ifdef AXI_LITE_TIMEOUT_EN
        .TIMEOUT(TIMEOUT),
`endif
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Slave configuration, written only by the stimulus process
    int aw_dly_c = 0, w_dly_c = 0, ar_dly_c = 0;
    bit ar_block = 1'b0, pre_en = 1'b0;
    logic [31:0] pre_seed = 32'd0;
    logic [7:0] corrupt_c = 8'hFF, bresp_c = 8'hFF;

    // Slave state and monitor records, written only by the slave process
    logic [31:0] mem [16];
    int aw_cnt, w_cnt, ar_cnt, cyc = 0;
    bit have_aw, have_w;
    logic [31:0] aw_lat, w_lat;
    int wr_total = 0, rd_total = 0, aw_hs = 0, w_hs = 0, proto_viol = 0;
    logic [31:0] wr_addr_log [256], wr_data_log [256], rd_addr_log [256];
    int wr_ev [256], rd_ev [256];
    logic prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr;
    logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
    logic [3:0] rix;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly_c);
    assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_dly_c);
    assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly_c) && !ar_block;
    assign M_AXI_RRESP   = 2'b00;
    assign rix = M_AXI_ARADDR[5:2];

    always @(posedge ACLK) cyc <= cyc + 1;

    // Memory slave with per-channel ready delay, BRESP injection and a VALID-stability monitor
    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            have_aw <= 1'b0; have_w <= 1'b0;
            M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
            M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= 32'd0;
            prev_awv <= 1'b0; prev_wv <= 1'b0; prev_arv <= 1'b0;
            prev_awr <= 1'b0; prev_wr <= 1'b0; prev_arr <= 1'b0;
        end else begin
            if (prev_awv && !prev_awr && (!M_AXI_AWVALID || M_AXI_AWADDR != prev_awaddr)) proto_viol <= proto_viol + 1;
            if (prev_wv && !prev_wr && (!M_AXI_WVALID || M_AXI_WDATA != prev_wdata)) proto_viol <= proto_viol + 1;
            if (prev_arv && !prev_arr && (!M_AXI_ARVALID || M_AXI_ARADDR != prev_araddr)) proto_viol <= proto_viol + 1;
            prev_awv <= M_AXI_AWVALID; prev_awr <= M_AXI_AWREADY; prev_awaddr <= M_AXI_AWADDR;
            prev_wv <= M_AXI_WVALID; prev_wr <= M_AXI_WREADY; prev_wdata <= M_AXI_WDATA;
            prev_arv <= M_AXI_ARVALID; prev_arr <= M_AXI_ARREADY; prev_araddr <= M_AXI_ARADDR;
            aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                have_aw <= 1'b1; aw_lat <= M_AXI_AWADDR; aw_hs <= aw_hs + 1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                have_w <= 1'b1; w_lat <= M_AXI_WDATA; w_hs <= w_hs + 1;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if (have_aw && have_w && !M_AXI_BVALID) begin
                mem[aw_lat[5:2]] <= w_lat;
                M_AXI_BVALID <= 1'b1;
                M_AXI_BRESP <= ({4'd0, aw_lat[5:2]} == bresp_c) ? 2'b10 : 2'b00;
                wr_addr_log[wr_total % 256] <= aw_lat;
                wr_data_log[wr_total % 256] <= w_lat;
                wr_ev[wr_total % 256] <= cyc;
                wr_total <= wr_total + 1;
                have_aw <= 1'b0; have_w <= 1'b0;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                M_AXI_RVALID <= 1'b1;
                if (pre_en) M_AXI_RDATA <= ({4'd0, rix} == corrupt_c) ? 32'hdeadbeef : pre_seed + {28'd0, rix};
                else M_AXI_RDATA <= mem[rix];
                rd_addr_log[rd_total % 256] <= M_AXI_ARADDR;
                rd_ev[rd_total % 256] <= cyc;
                rd_total <= rd_total + 1;
            end
        end
    end

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] seed;
        int aw_dly, w_dly, ar_dly;
        bit preload;
        logic [7:0] corrupt, bresp_idx;
        int exp_err, exp_wr, exp_rd;
    } vec_t;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (TXN_DONE !== 1'b1 && n < budget) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk({name, "_done"}, TXN_DONE, 1);
    endtask

    task automatic run_vec(input int v, input vec_t t);
        int wb, rb, awb, wbb;
        logic [31:0] e;
        aw_dly_c = t.aw_dly; w_dly_c = t.w_dly; ar_dly_c = t.ar_dly;
        pre_en = t.preload; pre_seed = t.seed; corrupt_c = t.corrupt; bresp_c = t.bresp_idx;
        wb = wr_total; rb = rd_total; awb = aw_hs; wbb = w_hs;
        @(negedge ACLK); MODE = t.mode; SEED = t.seed; INIT_AXI_TXN = 1'b1;
        @(posedge ACLK); #1;
        chk($sformatf("v%0d_start_flags", v), {BUSY, TXN_DONE, ERROR, ERR_COUNT}, {1'b1, 1'b0, 1'b0, 8'd0});
        @(negedge ACLK); INIT_AXI_TXN = 1'b0;
        wait_done($sformatf("v%0d", v), 600);
        chk($sformatf("v%0d_err_count", v), ERR_COUNT, t.exp_err);
        chk($sformatf("v%0d_error", v), ERROR, (t.exp_err != 0));
        chk($sformatf("v%0d_busy_end", v), BUSY, 0);
        chk($sformatf("v%0d_writes", v), wr_total - wb, t.exp_wr);
        chk($sformatf("v%0d_aw_hs", v), aw_hs - awb, t.exp_wr);
        chk($sformatf("v%0d_w_hs", v), w_hs - wbb, t.exp_wr);
        chk($sformatf("v%0d_reads", v), rd_total - rb, t.exp_rd);
        for (int k = 0; k < t.exp_wr; k++) begin
            e = t.seed + 32'(k);
            chk($sformatf("v%0d_wr_addr%0d", v, k), wr_addr_log[(wb + k) % 256], 32'(k * 4));
            chk($sformatf("v%0d_wr_data%0d", v, k), wr_data_log[(wb + k) % 256], e);
        end
        for (int k = 0; k < t.exp_rd; k++)
            chk($sformatf("v%0d_rd_addr%0d", v, k), rd_addr_log[(rb + k) % 256], 32'(k * 4));
        if (t.mode == 2'b11)
            chk($sformatf("v%0d_wr_before_rd", v), (wr_ev[(wb + 3) % 256] < rd_ev[rb % 256]), 1);
        if (t.mode == 2'b00)
            for (int k = 0; k < 3; k++)
                chk($sformatf("v%0d_interleave%0d", v, k), (rd_ev[(rb + k) % 256] < wr_ev[(wb + k + 1) % 256]), 1);
    endtask

    vec_t vecs [6];

    initial begin
        //          mode   seed          aw w  ar pre corrupt bresp  err wr rd
        vecs[0] = '{2'b00, 32'h0101FFFF, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 4, 4};
        vecs[1] = '{2'b00, 32'h12345678, 3, 0, 0, 0, 8'hFF, 8'hFF, 0, 4, 4};
        vecs[2] = '{2'b01, 32'hA0000000, 0, 3, 0, 0, 8'hFF, 8'hFF, 0, 4, 0};
        vecs[3] = '{2'b10, 32'h0101FFFF, 0, 0, 0, 1, 8'd2,  8'hFF, 1, 0, 4};
        vecs[4] = '{2'b11, 32'hFFFFFFFE, 1, 2, 0, 0, 8'hFF, 8'd1,  1, 4, 4};
        vecs[5] = '{2'b10, 32'h00000005, 0, 0, 2, 1, 8'hFF, 8'hFF, 0, 0, 4};

        ARESET = 1'b1; INIT_AXI_TXN = 1'b0; MODE = 2'b00; SEED = 32'd0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_ctrl", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY,
                           TXN_DONE, ERROR, BUSY, ERR_COUNT}, 0);
        chk("reset_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 0);
        chk("fixed_prot_strb", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, {3'b000, 3'b000, 4'hF});
        @(negedge ACLK); ARESET = 1'b0;

        for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

        // Reset while the write address is still being backpressured
        aw_dly_c = 6; w_dly_c = 0; pre_en = 1'b0; bresp_c = 8'hFF; corrupt_c = 8'hFF;
        @(negedge ACLK); MODE = 2'b01; SEED = 32'h55AA0000; INIT_AXI_TXN = 1'b1;
        @(negedge ACLK); INIT_AXI_TXN = 1'b0;
        @(negedge ACLK);
        chk("pre_reset_awvalid", M_AXI_AWVALID, 1);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        chk("midrun_reset_outputs", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY,
                                     M_AXI_RREADY, BUSY, TXN_DONE, ERR_COUNT}, 0);
        @(negedge ACLK); ARESET = 1'b0;
        run_vec(6, vecs[0]);

        // Start edge while busy must not restart the run
        begin
            int wb;
            aw_dly_c = 0; w_dly_c = 3;
            wb = wr_total;
            @(negedge ACLK); MODE = 2'b01; SEED = 32'h00001000; INIT_AXI_TXN = 1'b1;
            @(negedge ACLK); INIT_AXI_TXN = 1'b0;
            repeat (4) @(negedge ACLK);
            INIT_AXI_TXN = 1'b1;
            chk("midrun_busy", BUSY, 1);
            wait_done("midrun_init", 600);
            repeat (5) @(posedge ACLK);
            #1;
            chk("midrun_done_hold", {TXN_DONE, BUSY}, 2'b10);
            chk("midrun_writes", wr_total - wb, 4);
            @(negedge ACLK); INIT_AXI_TXN = 1'b0;
        end

`ifdef AXI_LITE_TIMEOUT_EN
        begin
            int n = 0;
            ar_block = 1'b1; pre_en = 1'b1; ar_dly_c = 0;
            @(negedge ACLK); MODE = 2'b10; SEED = 32'd0; INIT_AXI_TXN = 1'b1;
            while (M_AXI_ARVALID !== 1'b1 && n < 10) begin @(posedge ACLK); #1; n++; end
            chk("tmo_arvalid_rise", M_AXI_ARVALID, 1);
            @(negedge ACLK); INIT_AXI_TXN = 1'b0;
            n = 0;
            while (TXN_DONE !== 1'b1 && n < 40) begin @(posedge ACLK); #1; n++; end
            chk("tmo_latency_ok", (n <= 16), 1);
            chk("tmo_flags", {TIMEOUT, ERROR, M_AXI_ARVALID, ERR_COUNT}, {1'b1, 1'b1, 1'b0, 8'd1});
            ar_block = 1'b0;
        end
`endif

        chk("valid_stability", proto_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
